// File: rtl/enc4b5b_pkg.sv
// Shared constants and types for the 4B5B line encoder/transmitter and its matching receiver.
package enc4b5b_pkg;

  localparam int unsigned DEF_PC_BIT_CLKS   = 5208;
  localparam int unsigned DEF_LINE_BIT_CLKS = 4340;
  localparam int unsigned DEF_FIFO_DEPTH    = 4;
  localparam int unsigned FRAME_BITS        = 12;

  localparam logic [7:0] LED_OVERFLOW = 8'b1010_1010;
  localparam logic [7:0] LED_FRAMING  = 8'b1011_1011;

  // 4B5B code per nibble, index 15 leftmost; codes read MSB..LSB
  localparam logic [15:0][4:0] CODE_TABLE = {
    5'b11101, 5'b11100, 5'b11011, 5'b11010,
    5'b10111, 5'b10110, 5'b10011, 5'b10010,
    5'b01111, 5'b01110, 5'b01011, 5'b01010,
    5'b10101, 5'b10100, 5'b01001, 5'b11110
  };

  // Bit 0 leaves the line first, so each code goes out LSB first
  typedef struct packed {
    logic       stop;
    logic [4:0] code_hi;
    logic [4:0] code_lo;
    logic       start;
  } line_frame_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

  function automatic logic [4:0] enc_nibble(input logic [3:0] n);
    return CODE_TABLE[n];
  endfunction

  function automatic line_frame_t build_frame(input logic [7:0] b);
    line_frame_t f;
    f.start   = 1'b0;
    f.code_lo = enc_nibble(b[3:0]);
    f.code_hi = enc_nibble(b[7:4]);
    f.stop    = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/enc4b5b_tx_9600_uart_rx_8n1.sv
// 8N1 receiver: 2-flop input synchronizer, mid-bit sampling, 1-cycle valid / framing-error pulses.
module uart_rx_8n1
  import enc4b5b_pkg::*;
#(
  parameter int unsigned BIT_CLKS = DEF_PC_BIT_CLKS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       ferr_o
);

  localparam int unsigned CNT_W = $clog2(BIT_CLKS);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BIT_CLKS / 2 - 1);

  logic             sync1_q, sync2_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Start is re-checked at half a bit, then every later sample lands mid-bit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign data_o  = shift_q;
  assign valid_o = valid_q;
  assign ferr_o  = ferr_q;

endmodule

// File: rtl/enc4b5b_tx_9600.sv
// PC 8N1 bytes in, buffered, 4B5B-encoded and sent as 12-bit coded-line frames.
module enc4b5b_tx_9600
  import enc4b5b_pkg::*;
#(
  parameter int unsigned PC_BIT_CLKS   = DEF_PC_BIT_CLKS,
  parameter int unsigned LINE_BIT_CLKS = DEF_LINE_BIT_CLKS,
  parameter int unsigned FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
  input  logic       CLK_50M,
  input  logic       RST_N,
  input  logic       RS232_DCE_RXD,
  output logic       RS232_DTE_TXD,
  output logic [7:0] LED,
  output logic       ERR
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LCNT_W = $clog2(LINE_BIT_CLKS);
  localparam int unsigned BIT_W  = $clog2(FRAME_BITS);
  localparam logic [LCNT_W-1:0] LINE_LAST = LCNT_W'(LINE_BIT_CLKS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;

  uart_rx_8n1 #(.BIT_CLKS(PC_BIT_CLKS)) u_rx (
    .clk     (CLK_50M),
    .rst_n   (RST_N),
    .rxd_i   (RS232_DCE_RXD),
    .data_o  (rx_data),
    .valid_o (rx_valid),
    .ferr_o  (rx_ferr)
  );

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0] count_q, count_d;
  logic              full_c, nempty_c, push_c, pop_c, load_c;

  tx_state_e             tx_state_q, tx_state_d;
  logic [LCNT_W-1:0]     lcnt_q, lcnt_d;
  logic [BIT_W-1:0]      tbit_q, tbit_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [FRAME_BITS-1:0] frame_c;
  logic                  txd_q, txd_d;
  logic [7:0]            led_q, led_d;
  logic                  err_q, err_d;

  assign full_c   = (count_q == FIFO_FULL);
  assign nempty_c = (count_q != '0);
  assign push_c   = rx_valid && !full_c;
  assign frame_c  = build_frame(mem_q[rd_ptr_q]);

  always_ff @(posedge CLK_50M) begin
    if (push_c) mem_q[wr_ptr_q] <= rx_data;
  end

  always_comb begin
    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A frame is loaded from IDLE or straight off the end of a stop bit
  always_comb begin
    tx_state_d = tx_state_q;
    lcnt_d     = lcnt_q;
    tbit_d     = tbit_q;
    shreg_d    = shreg_q;
    txd_d      = txd_q;
    load_c     = 1'b0;
    pop_c      = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        txd_d  = 1'b1;
        load_c = nempty_c;
      end
      TX_SEND: begin
        if (lcnt_q == LINE_LAST) begin
          lcnt_d = '0;
          if (tbit_q == BIT_LAST) begin
            tx_state_d = TX_IDLE;
            txd_d      = 1'b1;
            load_c     = nempty_c;
          end else begin
            tbit_d  = tbit_q + 1'b1;
            shreg_d = {1'b1, shreg_q[FRAME_BITS-1:1]};
            txd_d   = shreg_q[1];
          end
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (load_c) begin
      pop_c      = 1'b1;
      shreg_d    = frame_c;
      txd_d      = frame_c[0];
      lcnt_d     = '0;
      tbit_d     = '0;
      tx_state_d = TX_SEND;
    end
  end

  // Error patterns take precedence over the byte display
  always_comb begin
    led_d = led_q;
    err_d = err_q;
    if (rx_valid) begin
      if (full_c) begin
        led_d = LED_OVERFLOW;
        err_d = 1'b1;
      end else begin
        led_d = rx_data;
      end
    end
    if (rx_ferr) begin
      led_d = LED_FRAMING;
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_state_q <= TX_IDLE;
      lcnt_q     <= '0;
      tbit_q     <= '0;
      shreg_q    <= '1;
      txd_q      <= 1'b1;
      led_q      <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_c)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      tx_state_q <= tx_state_d;
      lcnt_q     <= lcnt_d;
      tbit_q     <= tbit_d;
      shreg_q    <= shreg_d;
      txd_q      <= txd_d;
      led_q      <= led_d;
      err_q      <= err_d;
    end
  end

  assign RS232_DTE_TXD = txd_q;
  assign LED           = led_q;
  assign ERR           = err_q;

endmodule

// File: tb/tb_enc4b5b_tx_9600.sv
// Bench for enc4b5b_tx_9600: scaled bit periods, frame scoreboard, plus a stalled-line instance.
module tb_enc4b5b_tx_9600;

  localparam int PC         = 60;
  localparam int LINE       = 50;
  localparam int LINE_STALL = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a_n, rxd_a, txd_a, err_a;
  logic [7:0] led_a;
  logic       rst_b_n, rxd_b, txd_b, err_b;
  logic [7:0] led_b;

  enc4b5b_tx_9600 #(.PC_BIT_CLKS(PC), .LINE_BIT_CLKS(LINE), .FIFO_DEPTH(4)) dut (
    .CLK_50M(clk), .RST_N(rst_a_n), .RS232_DCE_RXD(rxd_a),
    .RS232_DTE_TXD(txd_a), .LED(led_a), .ERR(err_a)
  );

  enc4b5b_tx_9600 #(.PC_BIT_CLKS(PC), .LINE_BIT_CLKS(LINE_STALL), .FIFO_DEPTH(4)) dut_stall (
    .CLK_50M(clk), .RST_N(rst_b_n), .RS232_DCE_RXD(rxd_b),
    .RS232_DTE_TXD(txd_b), .LED(led_b), .ERR(err_b)
  );

  typedef struct {
    logic [7:0]  data;
    bit          stop_ok;
    logic [7:0]  exp_led;
    logic        exp_err;
    bit          has_frame;
    logic [11:0] exp_frame;  // MSB is the first bit on the line
  } vec_t;

  vec_t        vecs [4];
  logic [11:0] exp_q [$];
  int          checks = 0;
  int          failures = 0;
  bit          mon_busy = 1'b0;
  int          mon_bit = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [4:0] rev5(input logic [4:0] c);
    return {c[0], c[1], c[2], c[3], c[4]};
  endfunction

  function automatic logic [11:0] model_frame(input logic [7:0] b);
    logic [4:0] tbl [16];
    tbl = '{5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011, 5'b01110, 5'b01111,
            5'b10010, 5'b10011, 5'b10110, 5'b10111, 5'b11010, 5'b11011, 5'b11100, 5'b11101};
    return {1'b0, rev5(tbl[b[3:0]]), rev5(tbl[b[7:4]]), 1'b1};
  endfunction

  task automatic hold(input bit inst, input logic v, input int n);
    if (inst) rxd_b = v; else rxd_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input bit inst, input logic [7:0] b, input bit stop_ok);
    hold(inst, 1'b0, PC);
    for (int i = 0; i < 8; i++) hold(inst, b[i], PC);
    if (stop_ok) hold(inst, 1'b1, PC);
    else begin
      // short low stop so the receiver's restart attempt is rejected as a glitch
      hold(inst, 1'b0, 3 * PC / 4);
      hold(inst, 1'b1, PC - 3 * PC / 4);
    end
  endtask

  task automatic apply_vec(input int i);
    if (vecs[i].has_frame) exp_q.push_back(vecs[i].exp_frame);
    send_byte(1'b0, vecs[i].data, vecs[i].stop_ok);
    repeat (4) @(negedge clk);
    check($sformatf("vec%0d_led", i), led_a, vecs[i].exp_led);
    check($sformatf("vec%0d_err", i), err_a, vecs[i].exp_err);
    hold(1'b0, 1'b1, 2 * PC);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 20 * 12 * LINE) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_pending"}, exp_q.size() + int'(mon_busy), 0);
  endtask

  // Frame monitor: every cycle of each bit must match that bit's first cycle
  initial begin
    logic [11:0] got;
    logic [11:0] exp;
    bit          bad;
    int          cyc;
    got = '0; bad = 1'b0; cyc = 0;
    forever begin
      @(negedge clk);
      if (rst_a_n === 1'b1 && !mon_busy && txd_a === 1'b0) begin
        mon_busy = 1'b1; mon_bit = 0; cyc = 0; got = '0; bad = 1'b0;
      end
      if (mon_busy) begin
        if (rst_a_n !== 1'b1) mon_busy = 1'b0;
        else begin
          if (cyc == 0) got = {got[10:0], txd_a};
          else if (txd_a !== got[0]) bad = 1'b1;
          cyc++;
          if (cyc == LINE) begin
            cyc = 0;
            mon_bit++;
            if (mon_bit == 12) begin
              mon_busy = 1'b0;
              if (exp_q.size() == 0) check("unexpected_frame", {20'd0, got}, 32'hFFFF_FFFF);
              else begin
                exp = exp_q.pop_front();
                check("frame", {19'd0, bad, got}, {20'd0, exp});
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int n, lows;
    vecs[0] = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 12'b0_01111_01111_1};
    vecs[1] = '{8'h5A, 1'b1, 8'h5A, 1'b0, 1'b1, 12'b0_01101_11010_1};
    vecs[2] = '{8'h3C, 1'b0, 8'hBB, 1'b1, 1'b0, 12'h000};
    vecs[3] = '{8'h01, 1'b1, 8'h01, 1'b1, 1'b1, 12'b0_10010_01111_1};

    rxd_a = 1'b1; rxd_b = 1'b1; rst_a_n = 1'b0; rst_b_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd_a", txd_a, 1);
    check("rst_led_a", led_a, 8'h00);
    check("rst_err_a", err_a, 0);
    check("rst_txd_b", txd_b, 1);
    check("rst_led_b", led_b, 8'h00);
    check("rst_err_b", err_b, 0);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    repeat (5) @(negedge clk);

    apply_vec(0);
    apply_vec(1);

    b = 8'h00;
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      exp_q.push_back(model_frame(b));
      send_byte(1'b0, b, 1'b1);
    end
    hold(1'b0, 1'b1, PC);
    drain("burst");
    check("burst_err", err_a, 0);
    check("burst_led", led_a, b);

    apply_vec(2);
    apply_vec(3);
    drain("after_ferr");

    // reset in the middle of a coded frame
    exp_q.push_back(model_frame(8'hC3));
    send_byte(1'b0, 8'hC3, 1'b1);
    n = 0;
    while (!(mon_busy && mon_bit == 5) && n < 20 * LINE) begin
      @(negedge clk);
      n++;
    end
    check("reach_bit5", (mon_busy && mon_bit == 5), 1);
    @(posedge clk);
    #1 rst_a_n = 1'b0;
    #1 check("midframe_rst_txd", txd_a, 1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("midframe_rst_led", led_a, 8'h00);
    check("midframe_rst_err", err_a, 0);
    rst_a_n = 1'b1;
    lows = 0;
    repeat (3 * LINE) begin
      @(negedge clk);
      if (txd_a !== 1'b1) lows++;
    end
    check("post_rst_quiet", lows, 0);
    exp_q.push_back(model_frame(8'h96));
    send_byte(1'b0, 8'h96, 1'b1);
    hold(1'b0, 1'b1, PC);
    drain("post_rst");
    check("post_rst_led", led_a, 8'h96);

    // stalled line: one byte in TX, four buffered, sixth overflows
    for (int k = 0; k < 6; k++) begin
      send_byte(1'b1, 8'h11 + 8'(k), 1'b1);
      if (k == 4) begin
        check("stall_led5", led_b, 8'h15);
        check("stall_err5", err_b, 0);
      end
    end
    repeat (4) @(negedge clk);
    check("stall_led6", led_b, 8'hAA);
    check("stall_err6", err_b, 1);
    check("stall_txd_start", txd_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/enc4b5b_tx_9600.md
Name: enc4b5b_tx_9600

Overview:
- Opposite direction of the 4B5B line receiver.
- Accepts standard 8N1 bytes from the PC at 9600 baud and encodes each byte into two 4B5B symbols.
- Transmits each encoded byte as one coded-line frame at the line rate: start bit, 10 code bits, stop bit.
- Small FIFO decouples the two rates; LED shows the last byte accepted from the PC.

Parameters:
- PC_BIT_CLKS, 5208, CLK_50M cycles per PC-side bit (9600 baud).
- LINE_BIT_CLKS, 4340, CLK_50M cycles per coded-line bit (9600*1.2 baud).
- FIFO_DEPTH, 4, byte entries in the buffer; power of two.

Ports:
- CLK_50M  in  1  system clock, 50 MHz.
- RST_N  in  1  asynchronous active-low reset.
- RS232_DCE_RXD  in  1  8N1 serial data from the PC, idle high.
- RS232_DTE_TXD  out  1  coded-line serial output, idle high.
- LED  out  8  last accepted byte, or an error pattern.
- ERR  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (RST_N=0, asynchronous): RS232_DTE_TXD=1, LED=8'h00, ERR=0, FIFO empty, both FSMs idle, all counters 0.
- Input sync: RS232_DCE_RXD passes through a 2-flop synchronizer before any use.
- PC receiver FSM, states IDLE, START, DATA, STOP:
  - IDLE→START on synchronized low.
  - START: re-sample at PC_BIT_CLKS/2. If high, treat as a glitch and return to IDLE. If low, go to DATA.
  - DATA: 8 samples spaced PC_BIT_CLKS, LSB first.
  - STOP: sample once after another PC_BIT_CLKS.
  - Stop=1: push the byte into the FIFO and set LED=byte.
  - Stop=0 (framing error): drop the byte, LED=8'b1011_1011, ERR=1.
  - Return to IDLE in all cases.
- FIFO:
  - Push when full: drop the byte, LED=8'b1010_1010, ERR=1, FIFO contents unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - A push and pop in the same cycle are both honoured.
- Encoder (combinational, per nibble, 5-bit code written MSB..LSB):
  - 0:11110, 1:01001, 2:10100, 3:10101, 4:01010, 5:01011, 6:01110, 7:01111
  - 8:10010, 9:10011, A:10110, B:10111, C:11010, D:11011, E:11100, F:11101
- Coded frame, 12 bits, shifted out in this order:
  - start 0;
  - low-nibble code, LSB first;
  - high-nibble code, LSB first;
  - stop 1.
- Line transmitter FSM, states IDLE, SEND:
  - IDLE: if the FIFO is non-empty, pop one byte in the same cycle, load the 12-bit shift register, drive the start bit on the next cycle, go to SEND.
  - SEND: each bit is held exactly LINE_BIT_CLKS cycles. After the stop bit's full period, return to IDLE.
  - Back-to-back frames are allowed: the next start bit may follow the previous stop bit immediately.
- Latency: from the PC stop-bit sample to the coded start bit is at most 3 cycles when the FIFO is empty and TX is idle.
- Throughput: the coded frame lasts 12*4340=52080 cycles; the PC byte lasts 10*5208=52080 cycles. Sustained full-rate input therefore never overflows in steady state.
- LED priority: an error pattern written in a cycle overrides a byte write in the same cycle.
- Reset mid-frame: TX returns to 1 immediately; any partial PC byte is discarded.

Decomposition:
- Shared package holds:
  - the 4B5B code table constants (shared with the receiver's decode table);
  - the default bit-period constants;
  - the LED error patterns 8'b1010_1010 and 8'b1011_1011.
- One sub-module, uart_rx_8n1: synchronizer plus PC receiver FSM. It outputs a byte, a 1-cycle valid and a 1-cycle framing-error pulse.
- The FIFO, encoder and line TX live in the top module.

Test Plan:
- PC sends 0x00 → TXD frame 0,0,1,1,1,1,0,1,1,1,1,1, each bit 4340 cycles; LED=0x00; ERR=0.
- PC sends 0x5A → frame 0,0,1,1,0,1,1,1,0,1,0,1 (A=10110 then 5=01011, each LSB first); LED=0x5A.
- PC sends 0x3C with the stop bit forced 0 → no coded frame, LED=0xBB, ERR=1. A following valid 0x01 still transmits 0,1,0,0,1,0,0,1,1,1,1,1.
- 8 bytes sent with no gaps, TX observed → exactly 8 frames, in order, no overflow, ERR=0.
- Line TX stalled (LINE_BIT_CLKS overridden to 40000) while 6 bytes arrive → bytes 1–5 are accepted (one popped into TX, four held in the FIFO); byte 6 is dropped, LED=0xAA, ERR=1.
- RST_N pulsed low during bit 5 of a coded frame → TXD=1 within the same cycle, no further bits sent. The next byte sent produces a complete, correct frame.
